// File: rtl/ac_hyst_ctrl.sv
// ac_hyst_ctrl
// Three-state (IDLE / HEATING / COOLING) climate controller with separate
// on/off thresholds for hysteresis and a minimum-dwell timer that keeps the
// heater or compressor from short-cycling.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous, active-high reset
//   enable       0 forces IDLE (overrides dwell and temperature)
//   temp_valid   temperature sample valid this cycle
//   temperature  unsigned sample, TEMP_W bits
//   heating      heater drive  (state == HEATING), from the state register
//   cooling      cooler drive  (state == COOLING), from the state register
//   state        00 IDLE, 01 HEATING, 10 COOLING
//   dwell_busy   dwell counter non-zero, so a threshold exit is blocked
module ac_hyst_ctrl #(
  parameter int TEMP_W    = 5,
  parameter int HEAT_ON   = 18,
  parameter int HEAT_OFF  = 20,
  parameter int COOL_ON   = 22,
  parameter int COOL_OFF  = 20,
  parameter int MIN_DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] temperature,
  output logic              heating,
  output logic              cooling,
  output logic [1:0]        state,
  output logic              dwell_busy
);

  // $clog2(1) is 0; keep one bit so the counter stays a legal vector.
  // With MIN_DWELL=1 the load value is 0 and the counter never holds.
  localparam int CW = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;
  localparam logic [CW-1:0] DWELL_LOAD = CW'(MIN_DWELL - 1);

  localparam logic [TEMP_W-1:0] T_HEAT_ON  = TEMP_W'(HEAT_ON);
  localparam logic [TEMP_W-1:0] T_HEAT_OFF = TEMP_W'(HEAT_OFF);
  localparam logic [TEMP_W-1:0] T_COOL_ON  = TEMP_W'(COOL_ON);
  localparam logic [TEMP_W-1:0] T_COOL_OFF = TEMP_W'(COOL_OFF);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    HEATING = 2'b01,
    COOLING = 2'b10
  } st_e;

  st_e           st_q, st_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          eval;

  // Threshold decisions are only taken on a valid sample once dwell expired.
  assign eval = enable && temp_valid && (cnt_q == '0);

  always_comb begin
    st_nxt = st_q;
    if (!enable) begin
      st_nxt = IDLE;
    end else if (eval) begin
      case (st_q)
        IDLE: begin
          if (temperature <= T_HEAT_ON)      st_nxt = HEATING;
          else if (temperature >= T_COOL_ON) st_nxt = COOLING;
        end
        HEATING: if (temperature >= T_HEAT_OFF) st_nxt = IDLE;
        COOLING: if (temperature <= T_COOL_OFF) st_nxt = IDLE;
        default: st_nxt = IDLE;
      endcase
    end
  end

  // Any state change restarts the dwell window; otherwise count down to 0
  // independent of enable / temp_valid.
  always_comb begin
    cnt_nxt = cnt_q;
    if (st_nxt != st_q)    cnt_nxt = DWELL_LOAD;
    else if (cnt_q != '0)  cnt_nxt = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= IDLE;
      cnt_q <= '0;
    end else begin
      st_q  <= st_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign state      = st_q;
  assign heating    = (st_q == HEATING);
  assign cooling    = (st_q == COOLING);
  assign dwell_busy = (cnt_q != '0);

endmodule

// File: tb/tb_ac_hyst_ctrl.sv
module tb_ac_hyst_ctrl;
  localparam int TEMP_W = 5, HEAT_ON = 18, HEAT_OFF = 20, COOL_ON = 22,
                 COOL_OFF = 20, MIN_DWELL = 4;

  logic clk = 0, rst = 1, enable = 1, temp_valid = 1;
  logic [TEMP_W-1:0] temperature = 10;
  logic heating, cooling, dwell_busy;
  logic [1:0] state;

  int errors = 0, checks = 0;

  ac_hyst_ctrl #(.TEMP_W(TEMP_W), .HEAT_ON(HEAT_ON), .HEAT_OFF(HEAT_OFF),
                 .COOL_ON(COOL_ON), .COOL_OFF(COOL_OFF), .MIN_DWELL(MIN_DWELL))
  dut (.clk(clk), .rst(rst), .enable(enable), .temp_valid(temp_valid),
       .temperature(temperature), .heating(heating), .cooling(cooling),
       .state(state), .dwell_busy(dwell_busy));

  always #5 clk = ~clk;

  // Behavioural model: mode 0 idle / 1 heat / 2 cool, plus "edges since the
  // mode was entered". A threshold exit needs at least MIN_DWELL edges.
  int m_mode = 0;
  int m_age  = MIN_DWELL;
  bit m_init = 0;

  always @(posedge clk) begin
    int t, a, nm;
    t  = int'(temperature);
    a  = (m_age >= MIN_DWELL) ? MIN_DWELL : m_age + 1;
    nm = m_mode;
    if (rst) begin
      nm = 0; a = MIN_DWELL; m_init = 1;
    end else if (!enable) begin
      nm = 0;
    end else if (temp_valid && a >= MIN_DWELL) begin
      if (m_mode == 0 && t <= HEAT_ON)       nm = 1;
      else if (m_mode == 0 && t >= COOL_ON)  nm = 2;
      else if (m_mode == 1 && t >= HEAT_OFF) nm = 0;
      else if (m_mode == 2 && t <= COOL_OFF) nm = 0;
    end
    if (!rst && nm != m_mode) a = 0;
    m_mode = nm;
    m_age  = a;
  end

  // Every-cycle compare against the model once reset has been seen.
  always @(negedge clk) begin
    if (m_init) begin
      logic busy_exp;
      busy_exp = (m_age < MIN_DWELL - 1);
      checks++;
      if (int'(state) != m_mode || heating != (m_mode == 1) ||
          cooling != (m_mode == 2) || dwell_busy != busy_exp) begin
        errors++;
        $display("FAIL model t=%0t state=%0d heat=%0b cool=%0b busy=%0b required state=%0d busy=%0b",
                 $time, state, heating, cooling, dwell_busy, m_mode, busy_exp);
      end
      checks++;
      if (heating && cooling) begin
        errors++;
        $display("FAIL exclusive t=%0t heating and cooling both 1", $time);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs, take n edges, leave inputs stable 1 time unit after the edge.
  task automatic step(input int t, input int n);
    temperature = TEMP_W'(t);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a cold sample present
    rst = 1; enable = 1; temp_valid = 1;
    step(10, 2);
    chk("reset_state", state, 0);
    chk("reset_heat", heating, 0);
    chk("reset_cool", cooling, 0);
    chk("reset_busy", dwell_busy, 0);
    rst = 0;
    step(10, 1);
    chk("post_reset_heat", heating, 1);
    chk("post_reset_busy", dwell_busy, 1);

    // Heating hysteresis
    step(19, 10);  chk("heat_hold_19", state, 1);
    step(20, 1);   chk("heat_off_20", state, 0);
    step(19, 4);   chk("idle_19", state, 0);
    step(18, 1);   chk("heat_on_18", state, 1);
    step(19, 10);  chk("heat_hold_19b", state, 1);
    step(20, 1);   chk("heat_off_20b", state, 0);

    // Cooling hysteresis
    step(21, 4);   chk("idle_21", state, 0);
    chk("idle_busy_clear", dwell_busy, 0);
    step(22, 1);   chk("cool_on_22", state, 2);
    step(21, 4);   chk("cool_hold_21", state, 2);
    step(20, 1);   chk("cool_off_20", state, 0);

    // Dwell block: HEATING at N, then 25 -> IDLE at N+4, COOLING at N+8
    step(20, 4);
    step(18, 1);   chk("dwell_N", state, 1);
    step(25, 3);   chk("dwell_N3", state, 1);
    step(25, 1);   chk("dwell_N4", state, 0);
    step(25, 3);   chk("dwell_N7", state, 0);
    step(25, 1);   chk("dwell_N8", state, 2);

    // Enable override while dwell is busy
    chk("ovr_busy_before", dwell_busy, 1);
    enable = 0;
    step(25, 1);
    chk("ovr_state", state, 0);
    chk("ovr_cool", cooling, 0);
    chk("ovr_busy_reload", dwell_busy, 1);
    enable = 1;
    step(25, 3);   chk("ovr_wait3", state, 0);
    step(25, 1);   chk("ovr_cool4", state, 2);

    // Valid gating
    enable = 0;
    step(25, 1);   chk("gate_idle", state, 0);
    enable = 1; temp_valid = 0;
    step(5, 6);    chk("gate_hold", state, 0);
    temp_valid = 1;
    step(5, 1);    chk("gate_heat", state, 1);

    // Extremes of the sample range
    step(0, 4);    chk("temp0_heat", state, 1);
    step(31, 1);   chk("temp31_idle", state, 0);
    step(31, 4);   chk("temp31_cool", state, 2);

    // Reset mid-COOLING drops the drive on that edge
    rst = 1;
    step(31, 1);
    chk("rst_mid_cool", cooling, 0);
    chk("rst_mid_busy", dwell_busy, 0);
    rst = 0;
    step(31, 1);   chk("rst_recover_cool", state, 2);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
